// File: rtl/decoder_stream.sv
// Streaming 4-to-16 one-hot decoder: input FIFO feeding a registered valid/ready output stage.
// Optional transfer counter on xfer_count when DECODER_STATS_EN is defined.
module decoder_stream #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [3:0]                    in_code,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [15:0]                   decode_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef DECODER_STATS_EN
  ,
  output logic [CNT_W-1:0]              xfer_count
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
  localparam logic [LVL_W-1:0] LVL_ONE  = {{(LVL_W-1){1'b0}}, 1'b1};
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  function automatic logic [15:0] onehot16(input logic [3:0] code);
    onehot16 = 16'h0001 << code;
  endfunction

  logic [3:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic [LVL_W-1:0] level_nxt_s;
  logic             in_ready_r;
  logic [15:0]      dout_r;
  out_state_t       state_r;
  out_state_t       state_nxt_s;
  logic             load_s;
  logic             clear_s;
  logic             push_s;
  logic             pop_s;

  assign push_s     = in_valid && in_ready_r;
  assign pop_s      = load_s;
  assign in_ready   = in_ready_r;
  assign out_valid  = (state_r == ST_FULL);
  assign decode_out = dout_r;
  assign fifo_level = level_r;

  // Output stage next-state: load a new head whenever the stage is free or being drained.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    clear_s     = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (level_r != LVL_ZERO) begin
          state_nxt_s = ST_FULL;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          if (level_r != LVL_ZERO) begin
            load_s = 1'b1;
          end else begin
            state_nxt_s = ST_EMPTY;
            clear_s     = 1'b1;
          end
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
        clear_s     = 1'b1;
      end
    endcase
  end

  // FIFO occupancy after this edge's push/pop.
  always_comb begin
    level_nxt_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_ONE;
      2'b01:   level_nxt_s = level_r - LVL_ONE;
      default: level_nxt_s = level_r;
    endcase
  end

  // FIFO storage, pointers, level and the registered ready flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 4'h0;
      end
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      level_r    <= LVL_ZERO;
      in_ready_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= in_code;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      level_r    <= level_nxt_s;
      // Ready looks only at the registered level, so a full FIFO never accepts on a same-cycle pop.
      in_ready_r <= (level_nxt_s != LVL_FULL);
    end
  end

  // Output register: enable is sampled only when a word is loaded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_EMPTY;
      dout_r  <= 16'h0000;
    end else begin
      state_r <= state_nxt_s;
      if (load_s) begin
        dout_r <= enable ? onehot16(mem_r[rd_ptr_r]) : 16'h0000;
      end else if (clear_s) begin
        dout_r <= 16'h0000;
      end else begin
        dout_r <= dout_r;
      end
    end
  end

`ifdef DECODER_STATS_EN
  logic [CNT_W-1:0] xfer_cnt_r;
  assign xfer_count = xfer_cnt_r;

  // Completed output handshakes, wrapping naturally at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xfer_cnt_r <= {CNT_W{1'b0}};
    end else if (out_valid && out_ready) begin
      xfer_cnt_r <= xfer_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      xfer_cnt_r <= xfer_cnt_r;
    end
  end
`endif

endmodule
